stream_demux_1x8: RTL and testbench
===================================

Name: stream_demux_1x8

Overview:
- 1-to-8 demultiplexer with registered output stage and valid/ready handshake; the inverse of the team's 8x1 mux tree.
- Routes one input stream word to exactly one of 8 destination channels, selected by a 3-bit select sent with the word.
- Used to distribute writeback/result words from a single producer to 8 consumers, e.g. register-bank write ports or functional-unit queues.
- Single output holding register gives a 1-cycle latency and full throughput when the destination is ready.

Parameters:
- DATA_W, 32, width of the data word
- CNT_W, 16, width of each per-channel delivery counter (used only with DEMUX_CNT_EN)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept the input word this cycle
- in_data  input  DATA_W  input word
- in_sel  input  3  destination channel index 0..7
- chan_en  input  8  per-channel enable; a disabled channel's words are dropped
- out_valid  output  8  one-hot (or zero) valid per channel
- out_ready  input  8  per-channel ready
- out_data  output  DATA_W  held word, broadcast to all channels
- err_drop  output  1  one-cycle pulse: word accepted for a disabled channel and discarded
- cnt_rd_sel  input  3  counter read select
- cnt_rd_data  output  CNT_W  selected channel delivery count

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: holding register empty; out_valid=0, out_data=0, err_drop=0, all counters 0.
- Two states, tracked by hold_valid:
  - EMPTY -> FULL on accept of a word for an enabled channel.
  - FULL -> EMPTY on delivery with no new accept.
  - FULL -> FULL on simultaneous delivery and accept.
  - EMPTY stays EMPTY on accept of a word for a disabled channel.
- Output valid: out_valid[i] = hold_valid && (hold_sel == i). At most one bit set.
- in_ready = !hold_valid || out_ready[hold_sel]. Combinational from out_ready. No dependency on in_valid.
- Accept: in_valid && in_ready at a rising edge.
  - chan_en[in_sel]=1: hold_data<=in_data, hold_sel<=in_sel, hold_valid<=1. The word appears on out_data/out_valid the next cycle (latency 1).
  - chan_en[in_sel]=0: word consumed; holding register unchanged unless it is being delivered the same cycle; err_drop=1 the next cycle only.
- Delivery: out_valid[hold_sel] && out_ready[hold_sel] at a rising edge. hold_valid clears unless a new enabled word is accepted the same edge.
- Back-to-back accept and deliver sustains 1 word/cycle, including switching channel every cycle.
- Stall: while FULL and the destination is not ready:
  - out_data, hold_sel and out_valid stay stable;
  - in_ready=0;
  - out_ready on non-selected channels is ignored.
- chan_en is sampled only at acceptance. A held word is delivered even if its channel is disabled afterwards.
- out_valid must never drop without delivery, except by reset.
- Reset mid-operation: the held word is discarded; no partial state is kept.
- out_data keeps its last value when EMPTY. Consumers must qualify it with out_valid.

Optional Feature:
- Macro: STREAM_DEMUX_CNT_EN.
- Defined: 8 counters of CNT_W bits.
  - Counter i increments on each delivery to channel i.
  - Counters saturate at all-ones; no wrap.
  - cnt_rd_data = counter[cnt_rd_sel], combinational.
  - Drops are not counted.
- Undefined: no counters synthesized; cnt_rd_data tied to 0; ports still present.

Test Plan:
- Reset then stream: in_sel=0..7 in order, data 0xA0..0xA7, all out_ready=1, chan_en=0xFF -> out_valid=0x01,0x02..0x80 on consecutive cycles, each 1 cycle after accept, with matching data; in_ready stays 1.
- Stall: word 0x55 to ch3, out_ready[3]=0 for 4 cycles, out_ready[5]=1 -> out_valid=0x08 and data 0x55 stable; in_ready=0; a second word is accepted only on the cycle out_ready[3] rises; no gap after that.
- Drop: chan_en=0xFB, send 0x77 to ch2 -> err_drop pulses once; out_valid stays 0; in_ready stays 1.
- Enable change while held: word to ch6 stalled, then chan_en[6] cleared, then out_ready[6]=1 -> word still delivered once.
- Reset mid-operation: rst_n low while ch1 is holding 0x99 -> out_valid=0 immediately (async); after release no delivery of 0x99 occurs.
- With STREAM_DEMUX_CNT_EN, CNT_W=4: 20 deliveries to ch4 and 2 drops to ch4 -> cnt_rd_sel=4 reads 15 (saturated); other channels read 0. Without the macro, cnt_rd_data reads 0.

Source files
------------

// File: rtl/stream_demux_1x8.sv
//==============================================================================
// Module  : stream_demux_1x8
// Brief   : 1-to-8 stream demultiplexer, single registered holding stage with
//           valid/ready handshake. Optional per-channel delivery counters are
//           built when STREAM_DEMUX_CNT_EN is defined.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module stream_demux_1x8 #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_sel,
    input  logic [7:0]        chan_en,
    output logic [7:0]        out_valid,
    input  logic [7:0]        out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err_drop,
    input  logic [2:0]        cnt_rd_sel,
    output logic [CNT_W-1:0]  cnt_rd_data
);

    logic              hold_valid_q, hold_valid_d;
    logic [2:0]        hold_sel_q,   hold_sel_d;
    logic [DATA_W-1:0] hold_data_q,  hold_data_d;
    logic              err_drop_q,   err_drop_d;

    logic w_accept;
    logic w_accept_en;
    logic w_accept_drop;
    logic w_deliver;

    assign in_ready      = !hold_valid_q || out_ready[hold_sel_q];
    assign w_accept      = in_valid && in_ready;
    assign w_accept_en   = w_accept && chan_en[in_sel];
    assign w_accept_drop = w_accept && !chan_en[in_sel];
    assign w_deliver     = hold_valid_q && out_ready[hold_sel_q];

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_sel_d   = hold_sel_q;
        hold_data_d  = hold_data_q;
        err_drop_d   = w_accept_drop;
        // A new enabled word takes priority: it refills the stage being drained.
        if (w_accept_en) begin
            hold_valid_d = 1'b1;
            hold_sel_d   = in_sel;
            hold_data_d  = in_data;
        end else if (w_deliver) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_sel_q   <= 3'd0;
            hold_data_q  <= '0;
            err_drop_q   <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_sel_q   <= hold_sel_d;
            hold_data_q  <= hold_data_d;
            err_drop_q   <= err_drop_d;
        end
    end

    assign out_valid = hold_valid_q ? (8'b0000_0001 << hold_sel_q) : 8'b0000_0000;
    assign out_data  = hold_data_q;
    assign err_drop  = err_drop_q;

`ifdef STREAM_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q[gi];
            if (w_deliver && (hold_sel_q == 3'(gi)) && (cnt_q[gi] != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q[gi] + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[gi] <= '0;
            end else begin
                cnt_q[gi] <= cnt_d;
            end
        end
    end

    assign cnt_rd_data = cnt_q[cnt_rd_sel];
`else
    logic unused_cnt_rd_sel;

    assign unused_cnt_rd_sel = ^cnt_rd_sel;
    assign cnt_rd_data       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_1x8.sv
//==============================================================================
// Module  : tb_stream_demux_1x8
// Brief   : Directed self-checking bench for stream_demux_1x8 (CNT_W = 4).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_stream_demux_1x8;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [2:0]        in_sel;
    logic [7:0]        chan_en;
    logic [7:0]        out_valid;
    logic [7:0]        out_ready;
    logic [DATA_W-1:0] out_data;
    logic              err_drop;
    logic [2:0]        cnt_rd_sel;
    logic [CNT_W-1:0]  cnt_rd_data;

    int n_cmp;
    int n_err;

    stream_demux_1x8 #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .chan_en     (chan_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .err_drop    (err_drop),
        .cnt_rd_sel  (cnt_rd_sel),
        .cnt_rd_data (cnt_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic test_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = 3'd0;
        chan_en    = 8'hFF;
        out_ready  = 8'h00;
        cnt_rd_sel = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 8'h00) begin n_err++; $display("FAIL reset_out_valid: got %h want 00", out_valid); end
        n_cmp++;
        if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++;
        if (err_drop !== 1'b0) begin n_err++; $display("FAIL reset_err_drop: got %b want 0", err_drop); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++;
        if (cnt_rd_data !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt_rd_data); end
    endtask

    task automatic test_stream();
        logic [7:0]  exp_v;
        logic [31:0] exp_d;
        out_ready = 8'hFF;
        chan_en   = 8'hFF;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) begin
                in_valid = 1'b1;
                in_sel   = 3'(i);
                in_data  = 32'hA0 + 32'(i);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
            if (i > 0) begin
                exp_v = 8'h01 << (i - 1);
                exp_d = 32'hA0 + 32'(i - 1);
                n_cmp++;
                if (out_valid !== exp_v) begin n_err++; $display("FAIL stream_valid[%0d]: got %h want %h", i, out_valid, exp_v); end
                n_cmp++;
                if (out_data !== exp_d) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, exp_d); end
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 8'h00) begin n_err++; $display("FAIL stream_idle: got %h want 00", out_valid); end
`ifdef STREAM_DEMUX_CNT_EN
        for (int c = 0; c < 8; c++) begin
            cnt_rd_sel = 3'(c);
            #1;
            n_cmp++;
            if (cnt_rd_data !== 4'd1) begin n_err++; $display("FAIL stream_cnt[%0d]: got %0d want 1", c, cnt_rd_data); end
        end
`endif
    endtask

    task automatic test_stall();
        @(negedge clk);
        in_valid  = 1'b1;
        in_sel    = 3'd3;
        in_data   = 32'h55;
        out_ready = 8'h20;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                in_sel  = 3'd5;
                in_data = 32'h66;
            end
            #1;
            n_cmp++;
            if (out_valid !== 8'h08) begin n_err++; $display("FAIL stall_valid[%0d]: got %h want 08", i, out_valid); end
            n_cmp++;
            if (out_data !== 32'h55) begin n_err++; $display("FAIL stall_data[%0d]: got %h want 55", i, out_data); end
            n_cmp++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        out_ready = 8'h28;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 8'h20) begin n_err++; $display("FAIL stall_next_valid: got %h want 20", out_valid); end
        n_cmp++;
        if (out_data !== 32'h66) begin n_err++; $display("FAIL stall_next_data: got %h want 66", out_data); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 8'h00) begin n_err++; $display("FAIL stall_drain: got %h want 00", out_valid); end
    endtask

    task automatic test_drop();
        out_ready = 8'hFF;
        chan_en   = 8'hFB;
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 3'd2;
        in_data  = 32'h77;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL drop_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (err_drop !== 1'b1) begin n_err++; $display("FAIL drop_pulse: got %b want 1", err_drop); end
        n_cmp++;
        if (out_valid !== 8'h00) begin n_err++; $display("FAIL drop_valid: got %h want 00", out_valid); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (err_drop !== 1'b0) begin n_err++; $display("FAIL drop_pulse_end: got %b want 0", err_drop); end
        n_cmp++;
        if (out_valid !== 8'h00) begin n_err++; $display("FAIL drop_valid_after: got %h want 00", out_valid); end
        chan_en = 8'hFF;
    endtask

    task automatic test_enable_change();
        out_ready = 8'h00;
        chan_en   = 8'hFF;
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 3'd6;
        in_data  = 32'hC6;
        @(negedge clk);
        in_valid = 1'b0;
        chan_en  = 8'hBF;
        #1;
        n_cmp++;
        if (out_valid !== 8'h40) begin n_err++; $display("FAIL en_held_valid: got %h want 40", out_valid); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 8'h40) begin n_err++; $display("FAIL en_still_held: got %h want 40", out_valid); end
        n_cmp++;
        if (out_data !== 32'hC6) begin n_err++; $display("FAIL en_held_data: got %h want c6", out_data); end
        out_ready = 8'h40;
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 8'h00) begin n_err++; $display("FAIL en_delivered: got %h want 00", out_valid); end
        chan_en = 8'hFF;
    endtask

    task automatic test_reset_mid();
        out_ready = 8'h00;
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 3'd1;
        in_data  = 32'h99;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 8'h02) begin n_err++; $display("FAIL rstmid_held: got %h want 02", out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 8'h00) begin n_err++; $display("FAIL rstmid_async_valid: got %h want 00", out_valid); end
        n_cmp++;
        if (out_data !== 32'h0) begin n_err++; $display("FAIL rstmid_async_data: got %h want 0", out_data); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 8'h00) begin n_err++; $display("FAIL rstmid_no_delivery[%0d]: got %h want 00", i, out_valid); end
        end
    endtask

    task automatic test_counters();
        out_ready = 8'hFF;
        chan_en   = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sel   = 3'd4;
            in_data  = 32'h400 + 32'(i);
`ifdef STREAM_DEMUX_CNT_EN
            if (i == 15) begin
                cnt_rd_sel = 3'd4;
                #1;
                n_cmp++;
                if (cnt_rd_data !== 4'd14) begin n_err++; $display("FAIL cnt_partial: got %0d want 14", cnt_rd_data); end
            end
`endif
        end
        @(negedge clk);
        chan_en = 8'hEF;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
`ifdef STREAM_DEMUX_CNT_EN
        cnt_rd_sel = 3'd4;
        #1;
        n_cmp++;
        if (cnt_rd_data !== 4'd15) begin n_err++; $display("FAIL cnt_saturated: got %0d want 15", cnt_rd_data); end
        for (int c = 0; c < 8; c++) begin
            if (c != 4) begin
                cnt_rd_sel = 3'(c);
                #1;
                n_cmp++;
                if (cnt_rd_data !== 4'd0) begin n_err++; $display("FAIL cnt_other[%0d]: got %0d want 0", c, cnt_rd_data); end
            end
        end
`else
        for (int c = 0; c < 8; c++) begin
            cnt_rd_sel = 3'(c);
            #1;
            n_cmp++;
            if (cnt_rd_data !== 4'd0) begin n_err++; $display("FAIL cnt_tied_zero[%0d]: got %0d want 0", c, cnt_rd_data); end
        end
`endif
        chan_en = 8'hFF;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_stream();
        test_stall();
        test_drop();
        test_enable_change();
        test_reset_mid();
        test_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
